// File: rtl/boot_loader.sv
// Byte-stream program loader: assembles words, writes them into CPU RAM from
// address 0, verifies an XOR checksum and releases the CPU reset on success.
module boot_loader #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic                  cpu_rst_n,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int BYTES_PER_WORD = WORD_WIDTH / 8;
  localparam int BC_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES_PER_WORD - 1);
  localparam logic [31:0] DEPTH = 32'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  state_t                state_r;
  state_t                next_state_s;
  logic [7:0]            count_r;
  logic [BC_W-1:0]       byte_cnt_r;
  logic [7:0]            word_cnt_r;
  logic [WORD_WIDTH-1:0] shift_r;
  logic [7:0]            csum_r;

  logic                  xfer_s;
  logic                  word_end_s;
  logic                  last_word_s;
  logic                  in_range_s;
  logic                  write_s;
  logic [WORD_WIDTH-1:0] new_word_s;
  logic                  accept_s;
  logic                  done_s;
  logic                  error_s;

  function automatic logic [7:0] csum_update(input logic [7:0] csum, input logic [7:0] data);
    return csum ^ data;
  endfunction

  assign xfer_s      = in_valid & in_ready;
  assign new_word_s  = WORD_WIDTH'({shift_r, in_data});
  assign word_end_s  = (state_r == LOAD) & xfer_s & (byte_cnt_r == LAST_BYTE);
  assign last_word_s = word_end_s & (word_cnt_r == (count_r - 8'd1));
  // Words beyond the RAM depth are consumed and checksummed but never written.
  assign in_range_s  = (32'(word_cnt_r) < DEPTH);
  assign write_s     = word_end_s & in_range_s;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (xfer_s) begin
          next_state_s = (in_data == 8'd0) ? CHECK : LOAD;
        end else begin
          next_state_s = IDLE;
        end
      end
      LOAD: begin
        if (last_word_s) begin
          next_state_s = CHECK;
        end else begin
          next_state_s = LOAD;
        end
      end
      CHECK: begin
        if (xfer_s) begin
          next_state_s = (in_data == csum_r) ? DONE : ERROR;
        end else begin
          next_state_s = CHECK;
        end
      end
      DONE, ERROR: begin
        if (reload) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = state_r;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs track it.
  always_comb begin
    accept_s = 1'b0;
    done_s   = 1'b0;
    error_s  = 1'b0;
    case (next_state_s)
      IDLE, LOAD, CHECK: accept_s = 1'b1;
      DONE:              done_s   = 1'b1;
      ERROR:             error_s  = 1'b1;
      default:           accept_s = 1'b0;
    endcase
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_rst_n <= 1'b0;
    end else begin
      in_ready  <= accept_s;
      done      <= done_s;
      error     <= error_s;
      cpu_rst_n <= done_s;
    end
  end

  // RAM write port; address and data hold between strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= write_s;
      if (write_s) begin
        mem_addr  <= ADDR_WIDTH'(word_cnt_r);
        mem_wdata <= new_word_s;
      end
    end
  end

  // Written-word counter, cleared when a reload restarts the loader.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      words_loaded <= '0;
    end else if (((state_r == DONE) || (state_r == ERROR)) && reload) begin
      words_loaded <= '0;
    end else if (write_s) begin
      words_loaded <= words_loaded + (ADDR_WIDTH + 1)'(1);
    end
  end

  // Stream parsing: count latch, byte/word position, word assembly, checksum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r    <= 8'd0;
      byte_cnt_r <= '0;
      word_cnt_r <= 8'd0;
      shift_r    <= '0;
      csum_r     <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (xfer_s) begin
            count_r    <= in_data;
            byte_cnt_r <= '0;
            word_cnt_r <= 8'd0;
            shift_r    <= '0;
            csum_r     <= 8'd0;
          end
        end
        LOAD: begin
          if (xfer_s) begin
            shift_r <= new_word_s;
            csum_r  <= csum_update(csum_r, in_data);
            if (byte_cnt_r == LAST_BYTE) begin
              byte_cnt_r <= '0;
              word_cnt_r <= word_cnt_r + 8'd1;
            end else begin
              byte_cnt_r <= byte_cnt_r + BC_W'(1);
            end
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

endmodule
